// File: rtl/rq_pkg.sv
// Shared defaults and FSM state type for the Rq coefficient-add stream.
package rq_pkg;

  localparam int N_COEF_DEFAULT           = 701;
  localparam int NUM_WIDTH_LENGTH_DEFAULT = 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } rq_state_e;

endpackage

// File: rtl/rq_coef_add.sv
// Coefficient adder in Rq: the carry out of the top bit is dropped, giving the sum mod 2^width.
module rq_coef_add
  import rq_pkg::*;
#(
  parameter int NUM_WIDTH_LENGTH = NUM_WIDTH_LENGTH_DEFAULT
) (
  input  logic [NUM_WIDTH_LENGTH-1:0] i_a,
  input  logic [NUM_WIDTH_LENGTH-1:0] i_b,
  output logic [NUM_WIDTH_LENGTH-1:0] o_sum
);

  assign o_sum = i_a + i_b;

endmodule

// File: rtl/rq_add_stream.sv
// Streams two polynomials coefficient by coefficient and emits (a+b) mod q through a
// single-entry output register with valid/ready handshakes on both sides.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   ST_IDLE | waiting for start; no handshakes accepted
//   ST_RUN  | accepting pairs and draining sums until last beat
//   ST_DONE | one-cycle done pulse, then back to idle
module rq_add_stream
  import rq_pkg::*;
#(
  parameter int N_COEF           = N_COEF_DEFAULT,
  parameter int NUM_WIDTH_LENGTH = NUM_WIDTH_LENGTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_WIDTH_LENGTH-1:0] a_coef,
  input  logic [NUM_WIDTH_LENGTH-1:0] b_coef,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_WIDTH_LENGTH-1:0] out_coef,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
);

  localparam int                CNT_W   = $clog2(N_COEF + 1);
  localparam logic [CNT_W-1:0]  LP_N    = CNT_W'(N_COEF);
  localparam logic [CNT_W-1:0]  LP_LAST = CNT_W'(N_COEF - 1);

  rq_state_e                   r_state;
  rq_state_e                   w_state_nxt;
  logic [CNT_W-1:0]            r_in_cnt;
  logic [CNT_W-1:0]            r_out_cnt;
  logic                        r_out_valid;
  logic                        r_out_last;
  logic [NUM_WIDTH_LENGTH-1:0] r_out_coef;
  logic [NUM_WIDTH_LENGTH-1:0] w_sum;
  logic                        w_in_ready;
  logic                        w_in_hs;
  logic                        w_out_hs;
  logic                        w_start_ok;

  rq_coef_add #(
    .NUM_WIDTH_LENGTH(NUM_WIDTH_LENGTH)
  ) u_coef_add (
    .i_a  (a_coef),
    .i_b  (b_coef),
    .o_sum(w_sum)
  );

  // A full output register may take a new pair in the same cycle it drains.
  assign w_in_ready = (r_state == ST_RUN) && (r_in_cnt < LP_N) &&
                      (!r_out_valid || out_ready);
  assign w_in_hs    = in_valid && w_in_ready;
  assign w_out_hs   = r_out_valid && out_ready;
  assign w_start_ok = (r_state == ST_IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_out_hs && r_out_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_coef  <= '0;
    end else if (w_start_ok) begin
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_in_hs) begin
        r_in_cnt    <= r_in_cnt + 1'b1;
        r_out_coef  <= w_sum;
        r_out_valid <= 1'b1;
        r_out_last  <= (r_in_cnt == LP_LAST);
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
      if (w_out_hs) begin
        r_out_cnt <= r_out_cnt + 1'b1;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_coef  = r_out_coef;
  assign out_last  = r_out_last;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_rq_add_stream.sv
// Randomised and directed bench for rq_add_stream against a queue-based reference model.
module tb_rq_add_stream;

  localparam int N = 701;
  localparam int W = 13;
  localparam int Q = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a_coef = '0;
  logic [W-1:0] b_coef = '0;
  logic         in_ready;
  logic         out_valid;
  logic         out_last;
  logic         busy;
  logic         done;
  logic [W-1:0] out_coef;

  rq_add_stream dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_coef   (a_coef),
    .b_coef   (b_coef),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_coef (out_coef),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int coef;
    bit last;
  } exp_t;

  exp_t m_q[$];
  int   m_in_idx = 0;
  int   m_out_cnt = 0;
  bit   m_run = 0;
  bit   m_done_due = 0;
  bit   m_seen_done = 0;
  bit   prev_stall = 0;
  int   prev_coef = 0;
  bit   prev_last = 0;
  int   step_no = 0;
  int   first_hs_step = 0;
  int   done_step = 0;
  int   corner_obs[3];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_clear();
    m_q.delete();
    m_in_idx    = 0;
    m_out_cnt   = 0;
    m_run       = 0;
    m_done_due  = 0;
    prev_stall  = 0;
  endtask

  // One clock: observe at the falling edge, then return just after the rising edge.
  task automatic step();
    exp_t e;
    bit   was_idle;
    bit   exp_rdy;
    @(negedge clk);
    was_idle = !m_run && !m_done_due;
    chk("done", done, m_done_due);
    chk("busy", busy, m_run || m_done_due);
    if (m_done_due) begin
      m_seen_done = 1;
      done_step   = step_no;
    end
    m_done_due = 0;
    if (prev_stall) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_coef", out_coef, prev_coef);
      chk("hold_last", out_last, prev_last);
    end
    exp_rdy = m_run && (m_in_idx < N) && (!out_valid || out_ready);
    chk("in_ready", in_ready, exp_rdy);
    if (in_valid && in_ready) begin
      if (m_in_idx == 0) first_hs_step = step_no;
      e.coef = (int'(a_coef) + int'(b_coef)) % Q;
      e.last = (m_in_idx == N - 1);
      m_q.push_back(e);
      m_in_idx++;
    end
    if (out_valid && out_ready) begin
      if (m_q.size() == 0) begin
        chk("spurious_out", out_valid, 0);
      end else begin
        e = m_q.pop_front();
        if (m_out_cnt < 3) corner_obs[m_out_cnt] = int'(out_coef);
        chk("out_coef", out_coef, e.coef);
        chk("out_last", out_last, e.last);
        m_out_cnt++;
        if (e.last) begin
          m_run      = 0;
          m_done_due = 1;
        end
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_coef  = int'(out_coef);
    prev_last  = out_last;
    if (start && was_idle) begin
      model_clear();
      m_run       = 1;
      m_seen_done = 0;
    end
    @(posedge clk);
    #1;
    step_no++;
  endtask

  // mode 0: a=i,b=2i full rate; 1: same with a 5-cycle stall; 2: corner pairs; 3: random
  task automatic run_stream(input int mode, input int stop_at);
    int ca[3];
    int cb[3];
    int guard;
    ca = '{8191, 4000, 0};
    cb = '{1, 5000, 0};
    guard = 0;
    start     = 1;
    in_valid  = 0;
    out_ready = 1;
    step();
    start = 0;
    while (!m_seen_done && guard < 4000) begin
      if (stop_at >= 0 && m_in_idx == stop_at) break;
      case (mode)
        0, 1: begin
          in_valid  = 1;
          a_coef    = W'(m_in_idx % Q);
          b_coef    = W'((2 * m_in_idx) % Q);
          out_ready = (mode == 1) ? !(guard >= 200 && guard < 205) : 1'b1;
        end
        2: begin
          in_valid  = 1;
          out_ready = 1;
          if (m_in_idx < 3) begin
            a_coef = W'(ca[m_in_idx]);
            b_coef = W'(cb[m_in_idx]);
          end else begin
            a_coef = W'($urandom_range(0, Q - 1));
            b_coef = W'($urandom_range(0, Q - 1));
          end
        end
        default: begin
          in_valid  = ($urandom_range(0, 3) != 0);
          out_ready = ($urandom_range(0, 3) != 0);
          a_coef    = W'($urandom_range(0, Q - 1));
          b_coef    = W'($urandom_range(0, Q - 1));
          start     = ($urandom_range(0, 29) == 0);
        end
      endcase
      step();
      guard++;
    end
    start    = 0;
    in_valid = 0;
    if (stop_at < 0) begin
      chk("stream_done", m_seen_done, 1);
      chk("in_count", m_in_idx, N);
      chk("out_count", m_out_cnt, N);
      chk("q_empty", m_q.size(), 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_coef"}, out_coef, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
  endtask

  initial begin
    #1 rst_n = 0;
    #2;
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    step();
    step();
    rst_n = 1;

    run_stream(2, -1);
    chk("c8191p1", corner_obs[0], 0);
    chk("c4000p5000", corner_obs[1], 808);
    chk("c0p0", corner_obs[2], 0);

    run_stream(0, -1);
    chk("full_latency", done_step - first_hs_step, 702);

    run_stream(1, -1);
    run_stream(3, -1);

    run_stream(0, 350);
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 0;
    #1;
    check_reset_outputs("mid");
    model_clear();
    m_seen_done = 0;
    step();
    step();
    rst_n = 1;
    run_stream(0, -1);
    chk("post_rst_latency", done_step - first_hs_step, 702);

    run_stream(3, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rq_add_stream.md
RQ_ADD_STREAM -- requirements
Module: rq_add_stream

Interface
REQ-001 SHALL have parameter N_COEF, default 701, meaning the number of coefficients per polynomial.
REQ-002 SHALL have parameter NUM_WIDTH_LENGTH, default 13, meaning the coefficient width in bits (q = 2^13).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: begins one polynomial addition; honoured only in IDLE.
REQ-006 SHALL have port in_valid, input, 1 bit: a_coef/b_coef pair valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a pair this cycle.
REQ-008 SHALL have ports a_coef and b_coef, input, NUM_WIDTH_LENGTH bits each: coefficients with the same index.
REQ-009 SHALL have port out_valid, output, 1 bit: out_coef is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts out_coef.
REQ-011 SHALL have port out_coef, output, NUM_WIDTH_LENGTH bits: (a+b) mod q.
REQ-012 SHALL have port out_last, output, 1 bit: high with out_valid on coefficient index N_COEF-1.
REQ-013 SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse after the last output is accepted.

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-016 SHALL transition IDLE->RUN on start=1, clearing both counters.
REQ-017 SHALL transition RUN->DONE in the cycle the out_last beat completes (out_valid & out_ready & out_last).
REQ-018 SHALL transition DONE->IDLE unconditionally after one cycle; done=1 only in DONE.
REQ-019 SHALL complete an input handshake when in_valid & in_ready; an output handshake when out_valid & out_ready.
REQ-020 SHALL drive in_ready = (state==RUN) & (in_cnt < N_COEF) & (!out_valid | out_ready), so that a full single-entry output register accepts new data in the same cycle it drains.
REQ-021 SHALL register out_coef = a_coef + b_coef truncated to NUM_WIDTH_LENGTH bits, with the carry discarded (mod 2^13), on each input handshake; latency is 1 cycle from handshake to out_valid.
REQ-022 SHALL hold out_coef, out_valid and out_last stable while out_valid=1 and out_ready=0.
REQ-023 SHALL use in_cnt and out_cnt of ceil(log2(N_COEF+1)) bits; in_cnt increments on each input handshake, and out_cnt on each output handshake.
REQ-024 SHALL set out_last when the registered beat has in_cnt index N_COEF-1.
REQ-025 SHALL force in_ready=0 once in_cnt==N_COEF; extra in_valid SHALL be ignored.
REQ-026 SHALL ignore start while busy=1.
REQ-027 SHALL clear out_valid when the output register drains with no simultaneous input handshake.
REQ-028 SHALL allow sustained throughput of 1 coefficient/cycle when in_valid and out_ready stay high; a full polynomial SHALL take N_COEF+1 cycles from the first handshake to done.

Reset
REQ-029 SHALL, on rst_n=0 at any time including mid-polynomial, immediately set state=IDLE, in_cnt=out_cnt=0, out_valid=0, out_last=0, out_coef=0, done=0, busy=0 and in_ready=0.
REQ-030 SHALL accept start on the first rising clk edge after rst_n deasserts.

Structure
REQ-031 SHALL take N_COEF, NUM_WIDTH_LENGTH defaults and the FSM state enum from shared package rq_pkg.
REQ-032 SHALL place the modular sum in one combinational sub-module, rq_coef_add (a, b -> sum mod 2^NUM_WIDTH_LENGTH), and keep all sequential logic in rq_add_stream.

Verification
REQ-033 SHALL cover: a=8191, b=1 -> out_coef=0; a=4000, b=5000 -> out_coef=808; a=0, b=0 -> 0.
REQ-034 SHALL cover full stream with in_valid=out_ready=1, a[i]=i, b[i]=2i -> out_coef[i]=(3i) mod 8192, out_last on i=700 only, done one cycle later, 702 cycles total.
REQ-035 SHALL cover backpressure with out_ready=0 for 5 cycles mid-stream -> in_ready=0 after one accept, out_coef held, no coefficient lost or duplicated.
REQ-036 SHALL cover reset asserted at index 350 -> all outputs 0 asynchronously; new start then produces index 0 first.
REQ-037 SHALL cover start pulsed during RUN and extra in_valid after 701 accepts -> both ignored, counts unchanged.
